// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan
// Brief    : Four-digit multiplexed hex display scanner with a one-clk
//            all-anodes-off guard before each digit. Optional leading-zero
//            blanking is compiled in when SEG7_LZB_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n
);

    typedef enum logic [0:0] {
        SHOW  = 1'b0,
        GUARD = 1'b1
    } phase_t;

    localparam logic [6:0] c_SEG_OFF = 7'b1111111;
    localparam logic [3:0] c_AN_OFF  = 4'b1111;

    phase_t      r_phase,   w_phase_nxt;
    logic [1:0]  r_idx,     w_idx_nxt;
    logic [15:0] r_snap_v,  w_snap_v_nxt;
    logic [3:0]  r_snap_dp, w_snap_dp_nxt;
    logic [3:0]  r_an,      w_an_nxt;
    logic [6:0]  r_seg,     w_seg_nxt;
    logic        r_dp_n,    w_dp_n_nxt;

    logic [3:0]  w_nib;
    logic [6:0]  w_dec;
    logic [6:0]  w_glyph;

    function automatic logic [6:0] f_decode(input logic [3:0] n);
        case (n)
            4'h0:    f_decode = 7'b1000000;
            4'h1:    f_decode = 7'b1111001;
            4'h2:    f_decode = 7'b0100100;
            4'h3:    f_decode = 7'b0110000;
            4'h4:    f_decode = 7'b0011001;
            4'h5:    f_decode = 7'b0010010;
            4'h6:    f_decode = 7'b0000010;
            4'h7:    f_decode = 7'b1111000;
            4'h8:    f_decode = 7'b0000000;
            4'h9:    f_decode = 7'b0010000;
            4'hA:    f_decode = 7'b0001000;
            4'hB:    f_decode = 7'b0000011;
            4'hC:    f_decode = 7'b1000110;
            4'hD:    f_decode = 7'b0100001;
            4'hE:    f_decode = 7'b0000110;
            default: f_decode = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        w_nib = r_snap_v[3:0];
        case (r_idx)
            2'd1:    w_nib = r_snap_v[7:4];
            2'd2:    w_nib = r_snap_v[11:8];
            2'd3:    w_nib = r_snap_v[15:12];
            default: w_nib = r_snap_v[3:0];
        endcase
    end

    assign w_dec = f_decode(w_nib);

`ifdef SEG7_LZB_EN
    // A digit is blank when it and every digit to its left are zero; digit 0 always shows.
    logic w_blank;
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd1:    w_blank = (r_snap_v[15:4]  == 12'h000);
            2'd2:    w_blank = (r_snap_v[15:8]  == 8'h00);
            2'd3:    w_blank = (r_snap_v[15:12] == 4'h0);
            default: w_blank = 1'b0;
        endcase
    end
    assign w_glyph = w_blank ? c_SEG_OFF : w_dec;
`else
    assign w_glyph = w_dec;
`endif

    always_comb begin
        w_phase_nxt   = r_phase;
        w_idx_nxt     = r_idx;
        w_snap_v_nxt  = r_snap_v;
        w_snap_dp_nxt = r_snap_dp;
        w_an_nxt      = r_an;
        w_seg_nxt     = r_seg;
        w_dp_n_nxt    = r_dp_n;
        case (r_phase)
            SHOW: begin
                if (tick) begin
                    w_idx_nxt   = r_idx + 2'd1;
                    w_an_nxt    = c_AN_OFF;
                    w_phase_nxt = GUARD;
                    // Snapshots only refresh at frame start so a frame never tears.
                    if (r_idx == 2'd3) begin
                        w_snap_v_nxt  = value;
                        w_snap_dp_nxt = dp;
                    end
                end
            end
            GUARD: begin
                w_an_nxt    = ~(4'b0001 << r_idx);
                w_seg_nxt   = w_glyph;
                w_dp_n_nxt  = ~r_snap_dp[r_idx];
                w_phase_nxt = SHOW;
            end
            default: w_phase_nxt = SHOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase   <= SHOW;
            r_idx     <= 2'd3;
            r_snap_v  <= 16'h0000;
            r_snap_dp <= 4'b0000;
            r_an      <= c_AN_OFF;
            r_seg     <= c_SEG_OFF;
            r_dp_n    <= 1'b1;
        end else begin
            r_phase   <= w_phase_nxt;
            r_idx     <= w_idx_nxt;
            r_snap_v  <= w_snap_v_nxt;
            r_snap_dp <= w_snap_dp_nxt;
            r_an      <= w_an_nxt;
            r_seg     <= w_seg_nxt;
            r_dp_n    <= w_dp_n_nxt;
        end
    end

    assign an   = r_an;
    assign seg  = r_seg;
    assign dp_n = r_dp_n;

endmodule
`default_nettype wire
